// File: rtl/hc4511_pkg.sv
// Shared types and constants for the HC4511 multiplexed scan controller.
package hc4511_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        LAMP  = 2'd0,
        IDLE  = 2'd1,
        BLANK = 2'd2,
        SHOW  = 2'd3
    } state_t;

    localparam logic BI_BLANK       = 1'b0;
    localparam logic BI_SHOW        = 1'b1;
    localparam logic LT_ON          = 1'b0;
    localparam logic LT_OFF         = 1'b1;
    localparam logic LE_TRANSPARENT = 1'b0;
    localparam logic LE_LATCHED     = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hc4511_scan_ctrl_if.sv
// Bus between the BCD datapath (master) and the scan controller (slave).
interface hc4511_scan_ctrl_if
    import hc4511_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                          EN;
    logic [BCD_W*NUM_DIGITS-1:0]   BCD_IN;
    logic                          UPDATE;
    logic                          LAMP_TEST_REQ;
    logic [BCD_W-1:0]              A;
    logic                          LE;
    logic                          BI_N;
    logic                          LT_N;
    logic [NUM_DIGITS-1:0]         DIG_SEL;
    logic                          FRAME_DONE;

    modport master (
        output EN, BCD_IN, UPDATE, LAMP_TEST_REQ,
        input  A, LE, BI_N, LT_N, DIG_SEL, FRAME_DONE
    );

    modport slave (
        input  EN, BCD_IN, UPDATE, LAMP_TEST_REQ,
        output A, LE, BI_N, LT_N, DIG_SEL, FRAME_DONE
    );
endinterface

// File: rtl/hc4511_tick_gen.sv
// Free-running prescaler: tick is high for one cycle every TICK_DIV clocks.
module hc4511_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/hc4511_scan_ctrl.sv
// Scan controller sharing one HC4511 between NUM_DIGITS common-cathode digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module hc4511_scan_ctrl
    import hc4511_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICK_DIV        = 1000,
    parameter int BLANK_TICKS     = 1,
    parameter int SHOW_TICKS      = 4,
    parameter int LAMP_TEST_TICKS = 64
) (
    input  logic               CLK,
    input  logic               RST,
    hc4511_scan_ctrl_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int PH_MAX = max3(BLANK_TICKS, SHOW_TICKS, LAMP_TEST_TICKS);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    logic                  tick;
    logic [BCD_W-1:0]      bcd_digit [NUM_DIGITS];
    logic [BCD_W-1:0]      shadow_reg [NUM_DIGITS];

    state_t                state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [PH_W-1:0]       phase_reg;
    logic [BCD_W-1:0]      a_reg;
    logic                  le_reg;
    logic                  bi_n_reg;
    logic                  lt_n_reg;
    logic [NUM_DIGITS-1:0] dig_sel_reg;
    logic                  frame_done_reg;

    logic                  phase_last;
    logic                  step_done;
    logic                  force_lamp;
    logic                  go_blank;
    logic                  go_show;
    logic                  go_idle;
    logic                  last_digit;
    logic [IDX_W-1:0]      idx_wrap;
    logic [IDX_W-1:0]      blank_idx;
    logic [NUM_DIGITS-1:0] dig_one_hot;
    logic                  show_bi_n;

    hc4511_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign bcd_digit[gi] = bus.BCD_IN[gi*BCD_W +: BCD_W];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow_reg[i] <= '0;
        end else if (bus.UPDATE) begin
            shadow_reg <= bcd_digit;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k]: digit k and every more significant digit hold zero.
    logic [NUM_DIGITS-1:0] upper_zero;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (shadow_reg[gi] == '0);
            end else begin : g_chain
                assign upper_zero[gi] = (shadow_reg[gi] == '0) && upper_zero[gi+1];
            end
        end
    endgenerate
    assign show_bi_n = ((idx_reg == '0) || !upper_zero[idx_reg]) ? BI_SHOW : BI_BLANK;
`else
    assign show_bi_n = BI_SHOW;
`endif

    always_comb begin
        phase_last = 1'b0;
        case (state_reg)
            LAMP:    phase_last = (phase_reg == PH_W'(LAMP_TEST_TICKS - 1));
            BLANK:   phase_last = (phase_reg == PH_W'(BLANK_TICKS - 1));
            SHOW:    phase_last = (phase_reg == PH_W'(SHOW_TICKS - 1));
            default: phase_last = 1'b0;
        endcase
    end

    assign step_done   = tick && phase_last;
    assign force_lamp  = bus.LAMP_TEST_REQ && (state_reg != LAMP);
    assign last_digit  = (idx_reg == IDX_W'(NUM_DIGITS - 1));
    assign idx_wrap    = last_digit ? '0 : idx_reg + 1'b1;
    assign blank_idx   = (state_reg == SHOW) ? idx_wrap : '0;
    assign dig_one_hot = NUM_DIGITS'(1) << idx_reg;

    assign go_blank = !force_lamp && (
                         (state_reg == LAMP && step_done && !bus.LAMP_TEST_REQ) ||
                         (state_reg == IDLE && bus.EN) ||
                         (state_reg == SHOW && step_done && bus.EN));
    assign go_show  = !force_lamp && (state_reg == BLANK) && step_done;
    assign go_idle  = !force_lamp && (state_reg == SHOW) && step_done && !bus.EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= LAMP;
            idx_reg        <= '0;
            phase_reg      <= '0;
            a_reg          <= '0;
            le_reg         <= LE_TRANSPARENT;
            bi_n_reg       <= BI_BLANK;
            lt_n_reg       <= LT_OFF;
            dig_sel_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= (state_reg == SHOW) && step_done && !force_lamp && last_digit;
            if (force_lamp) begin
                state_reg   <= LAMP;
                phase_reg   <= '0;
                idx_reg     <= '0;
                lt_n_reg    <= LT_ON;
                bi_n_reg    <= BI_SHOW;
                le_reg      <= LE_TRANSPARENT;
                dig_sel_reg <= '1;
            end else if (go_blank) begin
                // A is sampled from the shadow before any same-cycle UPDATE lands.
                state_reg   <= BLANK;
                phase_reg   <= '0;
                idx_reg     <= blank_idx;
                a_reg       <= shadow_reg[blank_idx];
                lt_n_reg    <= LT_OFF;
                bi_n_reg    <= BI_BLANK;
                le_reg      <= LE_TRANSPARENT;
                dig_sel_reg <= '0;
            end else if (go_show) begin
                state_reg   <= SHOW;
                phase_reg   <= '0;
                lt_n_reg    <= LT_OFF;
                bi_n_reg    <= show_bi_n;
                le_reg      <= LE_LATCHED;
                dig_sel_reg <= dig_one_hot;
            end else if (go_idle) begin
                state_reg   <= IDLE;
                phase_reg   <= '0;
                idx_reg     <= '0;
                lt_n_reg    <= LT_OFF;
                bi_n_reg    <= BI_BLANK;
                le_reg      <= LE_TRANSPARENT;
                dig_sel_reg <= '0;
            end else begin
                // Lamp phase saturates at its last count while the request is held.
                if (tick && !phase_last && state_reg != IDLE) begin
                    phase_reg <= phase_reg + 1'b1;
                end
                if (state_reg == LAMP) begin
                    lt_n_reg    <= LT_ON;
                    bi_n_reg    <= BI_SHOW;
                    le_reg      <= LE_TRANSPARENT;
                    dig_sel_reg <= '1;
                end
            end
        end
    end

    assign bus.A          = a_reg;
    assign bus.LE         = le_reg;
    assign bus.BI_N       = bi_n_reg;
    assign bus.LT_N       = lt_n_reg;
    assign bus.DIG_SEL    = dig_sel_reg;
    assign bus.FRAME_DONE = frame_done_reg;
endmodule

// File: tb/tb_hc4511_scan_ctrl.sv
// Randomized scoreboard bench for hc4511_scan_ctrl against a tick-level behavioural model.
module tb_hc4511_scan_ctrl;
    localparam int ND = 4;
    localparam int TD = 4;
    localparam int BT = 1;
    localparam int ST = 4;
    localparam int LT = 2;
    localparam int NCYC = 5000;

    localparam int M_LAMP  = 0;
    localparam int M_IDLE  = 1;
    localparam int M_BLANK = 2;
    localparam int M_SHOW  = 3;

    typedef struct packed {
        logic [3:0]    a;
        logic          le;
        logic          bi_n;
        logic          lt_n;
        logic [ND-1:0] dig;
        logic          fd;
    } out_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    hc4511_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    hc4511_scan_ctrl #(
        .NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_TICKS(BT),
        .SHOW_TICKS(ST), .LAMP_TEST_TICKS(LT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    out_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   dut_frames = 0;
    int   model_frames = 0;

    // Behavioural model: elapsed ticks per state, prescaler as a modulo counter.
    int         m_state;
    int         m_presc;
    int         m_elapsed;
    int         m_idx;
    logic [3:0] m_shadow [ND];
    out_t       m_out;

    task automatic model_edge();
        bit tick;
        int ns;
        int ni;
        bit fd;
        bit req;
        bit en;
        req = bus.LAMP_TEST_REQ;
        en  = bus.EN;
        if (RST) begin
            m_state = M_LAMP; m_presc = 0; m_elapsed = 0; m_idx = 0;
            for (int j = 0; j < ND; j++) m_shadow[j] = 4'd0;
            m_out = '{a: 4'd0, le: 1'b0, bi_n: 1'b0, lt_n: 1'b1, dig: '0, fd: 1'b0};
            return;
        end
        tick    = (m_presc == TD - 1);
        m_presc = (m_presc + 1) % TD;
        fd = 1'b0; ns = m_state; ni = m_idx;
        if (req && m_state != M_LAMP) begin
            ns = M_LAMP; ni = 0;
        end else begin
            case (m_state)
                M_LAMP:  if (tick && m_elapsed + 1 >= LT && !req) begin ns = M_BLANK; ni = 0; end
                M_IDLE:  if (en) begin ns = M_BLANK; ni = 0; end
                M_BLANK: if (tick && m_elapsed + 1 == BT) ns = M_SHOW;
                default: if (tick && m_elapsed + 1 == ST) begin
                    fd = (m_idx == ND - 1);
                    if (en) begin ns = M_BLANK; ni = (m_idx + 1) % ND; end
                    else begin ns = M_IDLE; ni = 0; end
                end
            endcase
        end
        if (ns != m_state) m_elapsed = 0;
        else if (tick) m_elapsed++;
        m_out.fd = fd;
        if (fd) model_frames++;
        case (ns)
            M_LAMP: begin m_out.lt_n = 0; m_out.bi_n = 1; m_out.le = 0; m_out.dig = '1; end
            M_IDLE: begin m_out.lt_n = 1; m_out.bi_n = 0; m_out.le = 0; m_out.dig = '0; end
            M_BLANK: begin
                m_out.lt_n = 1; m_out.bi_n = 0; m_out.le = 0; m_out.dig = '0;
                if (m_state != M_BLANK) m_out.a = m_shadow[ni];
            end
            default: begin
                m_out.lt_n = 1; m_out.le = 1; m_out.dig = ND'(1) << ni;
                if (m_state != M_SHOW) begin
                    m_out.bi_n = 1;
`ifdef LEADING_ZERO_BLANK_EN
                    if (ni > 0) begin
                        bit allz;
                        allz = 1'b1;
                        for (int j = ni; j < ND; j++) if (m_shadow[j] != 4'd0) allz = 1'b0;
                        if (allz) m_out.bi_n = 0;
                    end
`endif
                end
            end
        endcase
        m_state = ns; m_idx = ni;
        if (bus.UPDATE) for (int j = 0; j < ND; j++) m_shadow[j] = bus.BCD_IN[4*j +: 4];
    endtask

    // Monitor: outputs are valid every cycle; compare one scoreboard entry per edge.
    always @(posedge CLK) begin
        out_t act;
        out_t exp_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act = '{a: bus.A, le: bus.LE, bi_n: bus.BI_N, lt_n: bus.LT_N,
                    dig: bus.DIG_SEL, fd: bus.FRAME_DONE};
            if (act.fd) dut_frames++;
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL outputs cyc=%0d act a=%0h le=%b bi_n=%b lt_n=%b dig=%b fd=%b exp a=%0h le=%b bi_n=%b lt_n=%b dig=%b fd=%b",
                         cyc, act.a, act.le, act.bi_n, act.lt_n, act.dig, act.fd,
                         exp_v.a, exp_v.le, exp_v.bi_n, exp_v.lt_n, exp_v.dig, exp_v.fd);
            end
        end
    end

    initial begin
        int req_len;
        RST = 1'b1;
        bus.EN = 1'b0; bus.BCD_IN = '0; bus.UPDATE = 1'b0; bus.LAMP_TEST_REQ = 1'b0;
        req_len = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge CLK);
            cyc = c;
            if (c < 3) begin
                RST = 1'b1;
            end else begin
                RST = ($urandom_range(0, 1499) == 0);
                if (c == 3) bus.EN = 1'b1;
                else if ($urandom_range(0, 149) == 0) bus.EN = ~bus.EN;
                if (c == 4) begin
                    bus.UPDATE = 1'b1; bus.BCD_IN = 16'h1234;
                end else begin
                    bus.UPDATE = ($urandom_range(0, 19) == 0);
                    if (bus.UPDATE) bus.BCD_IN = 16'($urandom);
                end
                if (req_len > 0) begin
                    bus.LAMP_TEST_REQ = 1'b1; req_len--;
                end else begin
                    bus.LAMP_TEST_REQ = 1'b0;
                    if ($urandom_range(0, 399) == 0) req_len = $urandom_range(1, 12);
                end
            end
            model_edge();
            $display("txn cyc=%0d rst=%b en=%b upd=%b bcd=%h req=%b exp a=%0h le=%b bi_n=%b lt_n=%b dig=%b fd=%b",
                     c, RST, bus.EN, bus.UPDATE, bus.BCD_IN, bus.LAMP_TEST_REQ,
                     m_out.a, m_out.le, m_out.bi_n, m_out.lt_n, m_out.dig, m_out.fd);
            exp_q.push_back(m_out);
        end
        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d entries left required=0", exp_q.size());
        end
        checks++;
        if (dut_frames != model_frames) begin
            failures++;
            $display("FAIL frame_count act=%0d required=%0d", dut_frames, model_frames);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hc4511_scan_ctrl.md
Name: hc4511_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one HC4511 BCD-to-7-segment decoder between NUM_DIGITS common-cathode digits.
- Holds a shadow copy of the BCD word and, per digit slot, presents that digit's code on the decoder inputs.
- Uses the decoder's LE/BI_N/LT_N controls for ghost-free switching and enables one digit driver at a time.
- Runs a lamp test after reset and on request.
- Sits between the counter/datapath that produces BCD values and the HC4511 instance plus the digit drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
TICK_DIV, 1000, CLK cycles per scan tick (>=2)
BLANK_TICKS, 1, ticks per digit with display blanked while the decoder loads (>=1)
SHOW_TICKS, 4, ticks per digit lit (>=1)
LAMP_TEST_TICKS, 64, minimum ticks of lamp test (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
EN  in  1  scan enable
BCD_IN  in  4*NUM_DIGITS  digit k on [4k+3:4k]; digit 0 is least significant
UPDATE  in  1  capture BCD_IN into the shadow registers this cycle
LAMP_TEST_REQ  in  1  level request for lamp test
A  out  4  decoder BCD input
LE  out  1  decoder latch enable (1 = latched)
BI_N  out  1  decoder blanking, active-low
LT_N  out  1  decoder lamp test, active-low
DIG_SEL  out  NUM_DIGITS  one-hot digit driver enable, active-high
FRAME_DONE  out  1  one-cycle pulse after the last digit's SHOW phase

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). All outputs are registered.
- Reset values:
  - A=0, LE=0, BI_N=0, LT_N=1, DIG_SEL=0, FRAME_DONE=0.
  - Shadow registers=0, digit index idx=0, prescaler=0, phase counter=0, state=LAMP.
  - RST in any state, including mid-SHOW, applies these values on the next edge.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 for one cycle when count==TICK_DIV-1.
- Phase counter:
  - Counts ticks within the current state.
  - The state transitions on the tick where the count reaches N-1. The counter clears on every state change.
- States:
  - LAMP: LT_N=0, BI_N=1, LE=0, DIG_SEL=all ones. Exits to BLANK with idx=0 once LAMP_TEST_TICKS ticks have elapsed and LAMP_TEST_REQ=0. Otherwise it stays.
  - IDLE: BI_N=0, LT_N=1, DIG_SEL=0, LE=0. Goes to BLANK with idx=0 on the first cycle with EN=1.
  - BLANK: BI_N=0, LE=0 (decoder transparent), DIG_SEL=0. A is loaded on the entry edge from shadow[idx]. After BLANK_TICKS ticks, goes to SHOW.
  - SHOW: LE=1, BI_N=1, DIG_SEL=one-hot(idx), A held. After SHOW_TICKS ticks:
    - If idx==NUM_DIGITS-1, idx wraps to 0 and FRAME_DONE pulses; otherwise idx+1.
    - Next state is BLANK if EN=1, else IDLE with idx=0.
- EN is sampled only at the end of SHOW and in IDLE. A deassertion mid-phase completes the current digit.
- LAMP_TEST_REQ=1 in any non-LAMP state forces state LAMP on the next edge. The phase counter clears and idx is set to 0.
- Shadow capture with UPDATE=1:
  - Shadow registers load on the next edge.
  - A reads shadow on BLANK entry, so an UPDATE in the same cycle as BLANK entry affects the following digit slot, not the current one.
- Codes >9 are passed through unchanged; the HC4511 blanks them.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, BI_N=0 for digit idx>0 when shadow[idx] and all higher digits are 0. Digit 0 is always shown. DIG_SEL still walks normally.
- Undefined: every digit is shown.

Decomposition:
- Package hc4511_pkg:
  - State enum (LAMP, IDLE, BLANK, SHOW).
  - BCD width constant (4).
  - Blank/lamp-test control constant values.
- One sub-module, hc4511_tick_gen: prescaler that outputs tick, parameter TICK_DIV.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=4, BLANK_TICKS=1, SHOW_TICKS=4, LAMP_TEST_TICKS=2 unless stated.
1. Reset release with EN=1:
   - LT_N=0 and DIG_SEL=4'b1111 for 8 cycles.
   - Then BLANK: BI_N=0, DIG_SEL=0, A=0.
2. BCD_IN=16'h1234 with an UPDATE pulse before the lamp test ends:
   - Per-digit sequence (A, DIG_SEL): (4, 0001), (3, 0010), (2, 0100), (1, 1000).
   - Each digit shows 4 cycles BLANK then 16 cycles SHOW with LE=1.
   - FRAME_DONE pulses once after digit 3.
3. EN dropped during digit 1 SHOW:
   - Digit 1 SHOW completes, then IDLE with DIG_SEL=0, BI_N=0.
   - EN=1 restarts at digit 0 with A=4.
4. LAMP_TEST_REQ held 3 cycles mid-SHOW of digit 2:
   - Next cycle LT_N=0, DIG_SEL=1111 for 8 cycles.
   - Then BLANK with idx=0.
5. UPDATE to 16'h5678 on the BLANK-entry cycle of digit 1:
   - Digit 1 shows 3 (old value).
   - Digit 2 shows 6.
   - Next frame digit 0 shows 8.
6. With LEADING_ZERO_BLANK_EN and BCD_IN=16'h0070:
   - Digits 3 and 2 have BI_N=0 in SHOW.
   - Digits 1 and 0 show 7 and 0.
   - RST asserted mid-frame returns all outputs to reset values on the next edge.
